// File: rtl/lb_pkg.sv
// Shared types and control-word layout for the region scheduler and load balancer.
package lb_pkg;

    localparam int unsigned OID_W           = 16;
    localparam int unsigned BUSY_W          = 16;
    localparam int unsigned STAT_W          = 32;
    localparam int unsigned CTRL_W          = 32;
    localparam int unsigned CTRL_VALID_BIT  = 31;
    localparam int unsigned CTRL_REGION_LSB = 16;
    localparam int unsigned CTRL_REGION_W   = 8;
    localparam int unsigned CTRL_OID_LSB    = 0;

    localparam logic [OID_W-1:0] OID_NONE = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECIDE,
        ST_PR_WAIT,
        ST_DISPATCH
    } sched_state_t;

    typedef struct packed {
        logic [BUSY_W-1:0] busy;
        logic [OID_W-1:0]  oid;
    } region_stat_t;

    // Valid control word carrying a zero-extended region index and operator id.
    function automatic logic [CTRL_W-1:0] make_ctrl(
        input logic [CTRL_REGION_W-1:0] region,
        input logic [OID_W-1:0]         oid
    );
        logic [CTRL_W-1:0] ctrl;
        ctrl                                   = '0;
        ctrl[CTRL_VALID_BIT]                   = 1'b1;
        ctrl[CTRL_REGION_LSB +: CTRL_REGION_W] = region;
        ctrl[CTRL_OID_LSB +: OID_W]            = oid;
        return ctrl;
    endfunction

endpackage

// File: rtl/region_scheduler_region_select.sv
// Picks the least-busy region holding an operator, and the lowest-index idle region.
module region_select
    import lb_pkg::*;
#(
    parameter int unsigned N_REGIONS = 4,
    parameter int unsigned IDX_W     = 2
) (
    input  region_stat_t     stats [N_REGIONS],
    input  logic [OID_W-1:0] oid,
    output logic             hit,
    output logic [IDX_W-1:0] hit_idx,
    output logic             idle_found,
    output logic [IDX_W-1:0] idle_idx
);

    logic [BUSY_W-1:0] best_busy;

    // Strict less-than keeps the earlier (lower) index on busy ties.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        idle_found = 1'b0;
        idle_idx   = '0;
        best_busy  = '1;
        for (int unsigned r = 0; r < N_REGIONS; r++) begin
            if (stats[r].oid == oid && (!hit || stats[r].busy < best_busy)) begin
                hit       = 1'b1;
                hit_idx   = IDX_W'(r);
                best_busy = stats[r].busy;
            end
            if (stats[r].busy == '0 && !idle_found) begin
                idle_found = 1'b1;
                idle_idx   = IDX_W'(r);
            end
        end
    end

endmodule

// File: rtl/region_scheduler.sv
// Schedules one request at a time onto a loaded region, reconfiguring an idle one on a miss.
module region_scheduler
    import lb_pkg::*;
#(
    parameter int unsigned HTTP_META_WIDTH      = 98,
    parameter int unsigned HTTP_META_META_WIDTH = 48,
    parameter int unsigned HTTP_METHOD_WIDTH    = 32,
    parameter int unsigned OPERATOR_ID_WIDTH    = 16,
    parameter int unsigned N_REGIONS            = 4,
    parameter int unsigned PR_TIMEOUT           = 4096
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           meta_valid,
    output logic                           meta_ready,
    input  logic [HTTP_META_WIDTH-1:0]     meta_data,
    input  logic [N_REGIONS*STAT_W-1:0]    region_stats_in,
    input  logic                           pr_done,
    input  logic                           disp_ready,
    output logic                           disp_valid,
    output logic [CTRL_W-1:0]              lb_ctrl,
    output logic [CTRL_W-1:0]              pr_ctrl,
    output logic                           pr_err,
    output logic [15:0]                    drop_cnt
);

    localparam int unsigned IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
    localparam int unsigned TMO_W = (PR_TIMEOUT > 1) ? $clog2(PR_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PR_TIMEOUT - 1);
    localparam int unsigned FLAGS_LSB = HTTP_META_META_WIDTH + HTTP_METHOD_WIDTH;
    localparam int unsigned OID_LSB   = HTTP_META_WIDTH - OPERATOR_ID_WIDTH;

    sched_state_t      state;
    region_stat_t      stats [N_REGIONS];
    logic [OID_W-1:0]  oid_q;
    logic [IDX_W-1:0]  pr_region_q;
    logic [TMO_W-1:0]  tmo_cnt;

    logic              hit;
    logic              idle_found;
    logic [IDX_W-1:0]  hit_idx;
    logic [IDX_W-1:0]  idle_idx;

    // Only the operator id steers scheduling; the remaining fields pass through untouched.
    logic unused_meta;
    assign unused_meta = ^{meta_data[OID_LSB-1:FLAGS_LSB],
                           meta_data[HTTP_META_META_WIDTH +: HTTP_METHOD_WIDTH],
                           meta_data[HTTP_META_META_WIDTH-1:0]};

    // One-cycle-stale snapshot of region status.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned r = 0; r < N_REGIONS; r++) begin
                stats[r] <= '{busy: '0, oid: OID_NONE};
            end
        end else begin
            for (int unsigned r = 0; r < N_REGIONS; r++) begin
                stats[r] <= region_stat_t'(region_stats_in[r*STAT_W +: STAT_W]);
            end
        end
    end

    region_select #(
        .N_REGIONS (N_REGIONS),
        .IDX_W     (IDX_W)
    ) u_region_select (
        .stats      (stats),
        .oid        (oid_q),
        .hit        (hit),
        .hit_idx    (hit_idx),
        .idle_found (idle_found),
        .idle_idx   (idle_idx)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= ST_IDLE;
            meta_ready  <= 1'b0;
            disp_valid  <= 1'b0;
            lb_ctrl     <= '0;
            pr_ctrl     <= '0;
            pr_err      <= 1'b0;
            drop_cnt    <= '0;
            oid_q       <= OID_NONE;
            pr_region_q <= '0;
            tmo_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (meta_valid && meta_ready) begin
                        oid_q      <= OID_W'(meta_data[OID_LSB +: OPERATOR_ID_WIDTH]);
                        meta_ready <= 1'b0;
                        state      <= ST_DECIDE;
                    end else begin
                        meta_ready <= 1'b1;
                    end
                end

                ST_DECIDE: begin
                    if (oid_q == OID_NONE) begin
                        if (drop_cnt != 16'hFFFF) begin
                            drop_cnt <= drop_cnt + 16'd1;
                        end
                        meta_ready <= 1'b1;
                        state      <= ST_IDLE;
                    end else if (hit) begin
                        lb_ctrl    <= make_ctrl(CTRL_REGION_W'(hit_idx), oid_q);
                        disp_valid <= 1'b1;
                        state      <= ST_DISPATCH;
                    end else if (idle_found) begin
                        pr_ctrl     <= make_ctrl(CTRL_REGION_W'(idle_idx), oid_q);
                        pr_region_q <= idle_idx;
                        tmo_cnt     <= '0;
                        state       <= ST_PR_WAIT;
                    end
                    // No holder and no idle region: wait here for status to change.
                end

                ST_PR_WAIT: begin
                    if (pr_done) begin
                        pr_ctrl[CTRL_VALID_BIT] <= 1'b0;
                        lb_ctrl    <= make_ctrl(CTRL_REGION_W'(pr_region_q), oid_q);
                        disp_valid <= 1'b1;
                        state      <= ST_DISPATCH;
                    end else if (tmo_cnt == TMO_LAST) begin
                        pr_ctrl <= '0;
                        pr_err  <= 1'b1;
                        state   <= ST_DECIDE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                ST_DISPATCH: begin
                    if (disp_ready) begin
                        disp_valid              <= 1'b0;
                        lb_ctrl[CTRL_VALID_BIT] <= 1'b0;
                        meta_ready              <= 1'b1;
                        state                   <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_region_scheduler.sv
// Randomized and directed self-checking bench for region_scheduler against a request-level model.
module tb_region_scheduler;

    localparam int N      = 4;
    localparam int PR_TMO = 16;

    logic        aclk;
    logic        aresetn;
    logic        meta_valid;
    logic        meta_ready;
    logic [97:0] meta_data;
    logic [N*32-1:0] region_stats_in;
    logic        pr_done;
    logic        disp_ready;
    logic        disp_valid;
    logic [31:0] lb_ctrl;
    logic [31:0] pr_ctrl;
    logic        pr_err;
    logic [15:0] drop_cnt;

    region_scheduler #(
        .HTTP_META_WIDTH      (98),
        .HTTP_META_META_WIDTH (48),
        .HTTP_METHOD_WIDTH    (32),
        .OPERATOR_ID_WIDTH    (16),
        .N_REGIONS            (N),
        .PR_TIMEOUT           (PR_TMO)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .meta_valid      (meta_valid),
        .meta_ready      (meta_ready),
        .meta_data       (meta_data),
        .region_stats_in (region_stats_in),
        .pr_done         (pr_done),
        .disp_ready      (disp_ready),
        .disp_valid      (disp_valid),
        .lb_ctrl         (lb_ctrl),
        .pr_ctrl         (pr_ctrl),
        .pr_err          (pr_err),
        .drop_cnt        (drop_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the observable scheduler state.
    logic [15:0] m_oid  [N];
    logic [15:0] m_busy [N];
    logic [31:0] exp_lb;
    logic [31:0] exp_pr;
    logic [15:0] exp_drop;
    logic        exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge aclk);
    endtask

    function automatic logic [31:0] mkctl(input int r, input logic [15:0] oid);
        return {1'b1, 7'd0, 8'(r), oid};
    endfunction

    // kind: 0 drop, 1 hit, 2 reconfigure, 3 stall
    function automatic void decide(input logic [15:0] oid, output int kind, output int region);
        int holders[$];
        kind   = 3;
        region = 0;
        if (oid == 16'hFFFF) begin
            kind = 0;
            return;
        end
        for (int i = 0; i < N; i++) if (m_oid[i] == oid) holders.push_back(i);
        if (holders.size() > 0) begin
            region = holders[0];
            foreach (holders[j]) if (m_busy[holders[j]] < m_busy[region]) region = holders[j];
            kind = 1;
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (m_busy[i] == 16'd0) begin
                kind   = 2;
                region = i;
                return;
            end
        end
    endfunction

    task automatic apply_stats();
        for (int i = 0; i < N; i++) begin
            region_stats_in[i*32 +: 16]    = m_oid[i];
            region_stats_in[i*32+16 +: 16] = m_busy[i];
        end
    endtask

    task automatic set_region(input int i, input logic [15:0] oid, input logic [15:0] busy);
        m_oid[i]  = oid;
        m_busy[i] = busy;
    endtask

    // Offer one request; returns at the negedge after the accepting edge.
    task automatic send(input logic [15:0] oid);
        int t = 0;
        while (!meta_ready && t < 50) begin
            tick();
            t++;
        end
        check("meta_ready_before_send", 32'(meta_ready), 32'd1);
        meta_valid = 1'b1;
        meta_data  = {oid, 82'({$urandom, $urandom, $urandom})};
        tick();
        meta_valid = 1'b0;
        check("accepted_meta_ready_low", 32'(meta_ready), 32'd0);
        check("accepted_no_disp", 32'(disp_valid), 32'd0);
    endtask

    // Entered at the negedge where the PR start should be visible.
    task automatic finish_pr(input int region, input logic [15:0] oid, input int pr_delay);
        exp_pr = mkctl(region, oid);
        check("pr_ctrl_start", pr_ctrl, exp_pr);
        check("pr_wait_no_disp", 32'(disp_valid), 32'd0);
        for (int k = 0; k < pr_delay; k++) begin
            tick();
            check("pr_ctrl_hold", pr_ctrl, exp_pr);
        end
        pr_done = 1'b1;
        tick();
        pr_done = 1'b0;
        exp_pr[31] = 1'b0;
        exp_lb = mkctl(region, oid);
    endtask

    // Entered at the negedge where disp_valid should first be high.
    task automatic finish_dispatch(input int disp_delay);
        check("disp_lb_ctrl", lb_ctrl, exp_lb);
        check("disp_valid_high", 32'(disp_valid), 32'd1);
        check("disp_pr_ctrl", pr_ctrl, exp_pr);
        check("disp_meta_ready_low", 32'(meta_ready), 32'd0);
        for (int k = 0; k < disp_delay; k++) begin
            tick();
            check("backpressure_lb_stable", lb_ctrl, exp_lb);
            check("backpressure_valid", 32'(disp_valid), 32'd1);
        end
        disp_ready = 1'b1;
        tick();
        disp_ready = 1'b0;
        exp_lb[31] = 1'b0;
        check("post_disp_valid", 32'(disp_valid), 32'd0);
        check("post_disp_lb_ctrl", lb_ctrl, exp_lb);
        check("post_disp_meta_ready", 32'(meta_ready), 32'd1);
        check("pr_err_state", 32'(pr_err), 32'(exp_err));
    endtask

    task automatic run_req(input logic [15:0] oid, input int pr_delay, input int disp_delay);
        int kind;
        int region;
        decide(oid, kind, region);
        send(oid);
        tick();
        if (kind == 0) begin
            exp_drop = (exp_drop == 16'hFFFF) ? exp_drop : exp_drop + 16'd1;
            check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
            check("drop_no_disp", 32'(disp_valid), 32'd0);
            check("drop_meta_ready", 32'(meta_ready), 32'd1);
            check("drop_pr_ctrl", pr_ctrl, exp_pr);
        end else begin
            if (kind == 1) exp_lb = mkctl(region, oid);
            else finish_pr(region, oid, pr_delay);
            finish_dispatch(disp_delay);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        int region;
        logic [15:0] oid;

        aresetn         = 1'b0;
        meta_valid      = 1'b0;
        meta_data       = '0;
        pr_done         = 1'b0;
        disp_ready      = 1'b0;
        region_stats_in = '0;
        exp_lb = '0; exp_pr = '0; exp_drop = '0; exp_err = 1'b0;
        for (int i = 0; i < N; i++) set_region(i, 16'hFFFF, 16'd0);
        apply_stats();

        repeat (3) tick();
        check("rst_meta_ready", 32'(meta_ready), 32'd0);
        check("rst_disp_valid", 32'(disp_valid), 32'd0);
        check("rst_lb_ctrl", lb_ctrl, 32'd0);
        check("rst_pr_ctrl", pr_ctrl, 32'd0);
        check("rst_pr_err", 32'(pr_err), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        aresetn = 1'b1;
        tick();
        check("meta_ready_after_release", 32'(meta_ready), 32'd1);

        // Hit with min-busy selection.
        set_region(0, 16'd5, 16'd3);
        set_region(2, 16'd5, 16'd1);
        apply_stats();
        run_req(16'd5, 0, 0);
        check("tp_hit_region", lb_ctrl, 32'h0002_0005);

        // Miss served by reconfiguring the idle region.
        set_region(0, 16'd7, 16'd2);
        set_region(1, 16'hFFFF, 16'd0);
        set_region(2, 16'd8, 16'd1);
        set_region(3, 16'd8, 16'd1);
        apply_stats();
        run_req(16'd9, 10, 0);
        check("tp_pr_ctrl_after", pr_ctrl, 32'h0001_0009);

        // Stall until a region goes idle, then backpressured dispatch.
        for (int i = 0; i < N; i++) set_region(i, 16'(10 + i), 16'd1);
        apply_stats();
        send(16'd3);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("stall_meta_ready", 32'(meta_ready), 32'd0);
            check("stall_pr_ctrl", pr_ctrl, exp_pr);
            check("stall_disp", 32'(disp_valid), 32'd0);
        end
        set_region(3, 16'd13, 16'd0);
        apply_stats();
        tick();
        check("stall_snapshot_lag", pr_ctrl, exp_pr);
        tick();
        check("tp_stall_pr", pr_ctrl, 32'h8003_0003);
        finish_pr(3, 16'd3, 2);
        finish_dispatch(5);

        // PR timeout then retry.
        set_region(0, 16'd20, 16'd1);
        set_region(1, 16'hFFFF, 16'd0);
        set_region(2, 16'd21, 16'd1);
        set_region(3, 16'd21, 16'd1);
        apply_stats();
        send(16'd3);
        tick();
        exp_pr = mkctl(1, 16'd3);
        check("tmo_pr_start", pr_ctrl, exp_pr);
        repeat (PR_TMO - 1) tick();
        check("tmo_not_yet_err", 32'(pr_err), 32'(exp_err));
        check("tmo_not_yet_pr", pr_ctrl, exp_pr);
        tick();
        exp_err = 1'b1;
        exp_pr  = '0;
        check("tmo_pr_err", 32'(pr_err), 32'd1);
        check("tmo_pr_cleared", pr_ctrl, exp_pr);
        tick();
        finish_pr(1, 16'd3, 3);
        finish_dispatch(0);

        // Drops and saturation.
        run_req(16'hFFFF, 0, 0);
        force dut.drop_cnt = 16'hFFFF;
        tick();
        release dut.drop_cnt;
        exp_drop = 16'hFFFF;
        tick();
        check("drop_forced_hold", 32'(drop_cnt), 32'(exp_drop));
        run_req(16'hFFFF, 0, 0);

        // Randomized requests.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N; i++) begin
                m_oid[i]  = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom_range(1, 4));
                m_busy[i] = 16'($urandom_range(0, 3));
            end
            oid = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(1, 5));
            decide(oid, kind, region);
            if (kind == 3) m_busy[$urandom_range(0, N-1)] = 16'd0;
            apply_stats();
            run_req(oid, $urandom_range(0, 12), $urandom_range(0, 3));
        end

        // Asynchronous reset while waiting for PR.
        for (int i = 0; i < N; i++) set_region(i, 16'hFFFF, 16'd0);
        apply_stats();
        send(16'd7);
        tick();
        check("pre_reset_pr", pr_ctrl, mkctl(0, 16'd7));
        #2 aresetn = 1'b0;
        #1;
        exp_lb = '0; exp_pr = '0; exp_drop = '0; exp_err = 1'b0;
        check("async_meta_ready", 32'(meta_ready), 32'd0);
        check("async_disp_valid", 32'(disp_valid), 32'd0);
        check("async_lb_ctrl", lb_ctrl, exp_lb);
        check("async_pr_ctrl", pr_ctrl, exp_pr);
        check("async_pr_err", 32'(pr_err), 32'(exp_err));
        check("async_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        tick();
        aresetn = 1'b1;
        check("release_meta_ready_low", 32'(meta_ready), 32'd0);
        tick();
        check("release_meta_ready_high", 32'(meta_ready), 32'd1);
        set_region(2, 16'd7, 16'd0);
        apply_stats();
        run_req(16'd7, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
